// File: rtl/io_display_ctrl_if.sv
// CPU-to-display bus bundle.
//   memWrite/address/writeData : CPU write strobe, bus address, write data
//   digits/ledOut              : display register contents
//   busy/overflow/statusData   : decimal-conversion status and CPU-readable status word
// master = CPU side, slave = display controller side.
interface io_display_ctrl_if;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] digits;
  logic [15:0] ledOut;
  logic        busy;
  logic        overflow;
  logic [31:0] statusData;

  modport master (
    output memWrite, address, writeData,
    input  digits, ledOut, busy, overflow, statusData
  );

  modport slave (
    input  memWrite, address, writeData,
    output digits, ledOut, busy, overflow, statusData
  );
endinterface

// File: rtl/io_display_ctrl.sv
// Write-side display controller.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : io_display_ctrl_if.slave (CPU write bus in, display registers and status out)
// Hex writes land in the digit register immediately. Decimal writes run a
// 32-iteration double-dabble (shift-and-add-3) engine and commit the low eight
// BCD digits one cycle after the last shift. Any new hex/decimal write
// supersedes a conversion in flight.
module io_display_ctrl #(
  parameter logic [31:0] SEG_HEX_ADDR = 32'hFFFF_FFF0,
  parameter logic [31:0] LED_ADDR     = 32'hFFFF_FFC2,
  parameter logic [31:0] SEG_DEC_ADDR = 32'hFFFF_FFC4,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FFC6
) (
  input logic             clk,
  input logic             rst,
  io_display_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] digits_q, digits_d;
  logic [15:0] led_q, led_d;
  logic        ovf_q, ovf_d;

  logic        hex_wr_s, dec_wr_s, led_wr_s;
  logic [39:0] bcd_adj_s;
  state_t      fsm_state_s;
  logic [31:0] fsm_bin_s;
  logic [39:0] fsm_bcd_s;
  logic [4:0]  fsm_cnt_s;
  logic [31:0] fsm_digits_s;
  logic        fsm_ovf_s;

  // Add 3 to every BCD digit that is 5 or more, so the following shift carries correctly.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? (v[i*4 +: 4] + 4'd3) : v[i*4 +: 4];
    end
    return r;
  endfunction

  assign hex_wr_s  = bus.memWrite && (bus.address == SEG_HEX_ADDR);
  assign dec_wr_s  = bus.memWrite && (bus.address == SEG_DEC_ADDR);
  assign led_wr_s  = bus.memWrite && (bus.address == LED_ADDR);
  assign bcd_adj_s = bcd_adjust(bcd_q);

  // Conversion progress when no hex/decimal write intervenes.
  always_comb begin
    fsm_state_s  = state_q;
    fsm_bin_s    = bin_q;
    fsm_bcd_s    = bcd_q;
    fsm_cnt_s    = cnt_q;
    fsm_digits_s = digits_q;
    fsm_ovf_s    = ovf_q;
    case (state_q)
      IDLE: begin
        fsm_state_s = IDLE;
      end
      CONV: begin
        {fsm_bcd_s, fsm_bin_s} = {bcd_adj_s[38:0], bin_q, 1'b0};
        fsm_cnt_s = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          fsm_state_s = DONE;
        end else begin
          fsm_state_s = CONV;
        end
      end
      DONE: begin
        // bcd[31:0] is value mod 10^8; upper two digits flag overflow.
        fsm_digits_s = bcd_q[31:0];
        fsm_ovf_s    = |bcd_q[39:32];
        fsm_state_s  = IDLE;
      end
      default: begin
        fsm_state_s = IDLE;
      end
    endcase
  end

  // Final next-state: hex/decimal writes override the engine (latest write wins).
  always_comb begin
    state_d  = fsm_state_s;
    bin_d    = fsm_bin_s;
    bcd_d    = fsm_bcd_s;
    cnt_d    = fsm_cnt_s;
    digits_d = fsm_digits_s;
    ovf_d    = fsm_ovf_s;
    if (hex_wr_s) begin
      digits_d = bus.writeData;
      ovf_d    = ovf_q;
      state_d  = IDLE;
    end else if (dec_wr_s) begin
      bin_d    = bus.writeData;
      bcd_d    = 40'd0;
      cnt_d    = 5'd0;
      digits_d = digits_q;
      ovf_d    = ovf_q;
      state_d  = CONV;
    end else begin
      state_d  = fsm_state_s;
    end
    if (led_wr_s) begin
      led_d = bus.writeData[15:0];
    end else begin
      led_d = led_q;
    end
  end

  // State and display registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bin_q    <= 32'd0;
      bcd_q    <= 40'd0;
      cnt_q    <= 5'd0;
      digits_q <= 32'd0;
      led_q    <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      led_q    <= led_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.ledOut     = led_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overflow   = ovf_q;
  assign bus.statusData = (bus.address == STATUS_ADDR) ?
                          {30'd0, ovf_q, (state_q != IDLE)} : 32'd0;

endmodule

// File: tb/tb_io_display_ctrl.sv
// Self-checking bench for io_display_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model (pending value + remaining-cycle countdown).
module tb_io_display_ctrl;

  localparam logic [31:0] HEX = 32'hFFFF_FFF0;
  localparam logic [31:0] LED = 32'hFFFF_FFC2;
  localparam logic [31:0] DEC = 32'hFFFF_FFC4;
  localparam logic [31:0] STS = 32'hFFFF_FFC6;
  localparam logic [31:0] BAD = 32'hFFFF_FFC8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic cmp_en;

  io_display_ctrl_if bus ();

  io_display_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model
  logic [31:0]     m_digits;
  logic [15:0]     m_led;
  logic            m_ovf;
  int              m_rem;
  longint unsigned m_val;

  function automatic logic [31:0] dec8(input longint unsigned v);
    logic [31:0]     r;
    longint unsigned t;
    r = 32'd0;
    t = v % 64'd100000000;
    for (int i = 0; i < 8; i++) begin
      r = r | (32'(t % 64'd10) << (4 * i));
      t = t / 64'd10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_digits = 32'd0;
      m_led    = 16'd0;
      m_ovf    = 1'b0;
      m_rem    = 0;
      m_val    = 64'd0;
    end else begin
      if (bus.memWrite && bus.address == LED) m_led = bus.writeData[15:0];
      if (bus.memWrite && bus.address == HEX) begin
        m_digits = bus.writeData;
        m_rem    = 0;
      end else if (bus.memWrite && bus.address == DEC) begin
        m_val = 64'(bus.writeData);
        m_rem = 33;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_digits = dec8(m_val);
          m_ovf    = (m_val >= 64'd100000000);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("digits", bus.digits, m_digits);
      check("ledOut", {16'd0, bus.ledOut}, {16'd0, m_led});
      check("busy", {31'd0, bus.busy}, {31'd0, (m_rem > 0)});
      check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      check("statusData", bus.statusData,
            (bus.address == STS) ? {30'd0, m_ovf, (m_rem > 0)} : 32'd0);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    bus.memWrite  = 1'b1;
    bus.address   = a;
    bus.writeData = d;
    @(posedge clk);
    #2;
    bus.memWrite  = 1'b0;
    bus.address   = 32'd0;
    bus.writeData = 32'd0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          busy_cnt;
    n_cmp = 0;
    n_err = 0;
    cmp_en = 1'b0;
    rst = 1'b0;
    bus.memWrite  = 1'b0;
    bus.address   = 32'd0;
    bus.writeData = 32'd0;
    #12;
    check("rst_digits", bus.digits, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // 12345678: busy for exactly 33 cycles, digits held until commit
    wr(DEC, 32'd12345678);
    busy_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (i == 31) check("hold_digits", bus.digits, 32'd0);
    end
    check("busy_cycles", 32'(busy_cnt), 32'd33);
    @(negedge clk);
    check("dec_12345678", bus.digits, 32'h12345678);
    check("dec_busy_low", {31'd0, bus.busy}, 32'd0);
    check("dec_ovf0", {31'd0, bus.overflow}, 32'd0);

    // max value overflows, then zero clears overflow
    wr(DEC, 32'hFFFF_FFFF);
    wait_idle("max_done");
    check("dec_max", bus.digits, 32'h94967295);
    check("dec_max_ovf", {31'd0, bus.overflow}, 32'd1);
    wr(DEC, 32'd0);
    wait_idle("zero_done");
    check("dec_zero", bus.digits, 32'd0);
    check("dec_zero_ovf", {31'd0, bus.overflow}, 32'd0);

    // hex write aborts a conversion
    wr(DEC, 32'd99999999);
    repeat (9) @(posedge clk);
    wr(HEX, 32'hDEADBEEF);
    @(negedge clk);
    check("hex_abort", bus.digits, 32'hDEADBEEF);
    check("hex_abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("no_late_commit", bus.digits, 32'hDEADBEEF);

    // restart mid-conversion
    wr(DEC, 32'd11111111);
    repeat (19) @(posedge clk);
    wr(DEC, 32'd500);
    busy_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    check("restart_busy", 32'(busy_cnt), 32'd33);
    @(negedge clk);
    check("restart_digits", bus.digits, 32'h00000500);

    // LED during conversion, stray address, status word
    wr(DEC, 32'd77);
    repeat (5) @(posedge clk);
    wr(LED, 32'h0001A5A5);
    @(negedge clk);
    check("led_write", {16'd0, bus.ledOut}, 32'h0000A5A5);
    check("led_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle("led_done");
    check("led_conv_done", bus.digits, 32'h00000077);
    wr(BAD, 32'hFFFF_FFFF);
    @(negedge clk);
    check("bad_digits", bus.digits, 32'h00000077);
    check("bad_led", {16'd0, bus.ledOut}, 32'h0000A5A5);
    bus.address = STS;
    @(negedge clk);
    check("status_idle", bus.statusData, 32'd0);
    wr(DEC, 32'd123);
    bus.address = STS;
    @(negedge clk);
    check("status_busy", bus.statusData, 32'h1);
    bus.address = 32'd0;

    // asynchronous reset mid-conversion
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_digits", bus.digits, 32'd0);
    check("arst_led", {16'd0, bus.ledOut}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_ovf", {31'd0, bus.overflow}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      r = $urandom_range(0, 99);
      bus.memWrite  = ($urandom_range(0, 3) != 0);
      bus.writeData = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 99999999);
      if (r < 2)       a = HEX;
      else if (r < 5)  a = DEC;
      else if (r < 15) a = LED;
      else if (r < 30) a = STS;
      else if (r < 35) a = BAD;
      else             a = $urandom;
      bus.address = a;
    end
    @(posedge clk);
    #2;
    bus.memWrite = 1'b0;
    bus.address  = 32'd0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_display_ctrl.md
Name: io_display_ctrl

Overview:
- Write-side controller between the CPU memory-mapped IO bus and the display resources: 7-segment/VGA digit registers and LED register.
- Decodes CPU writes and commits hex writes to the digit register in one cycle.
- Decimal writes are converted by a sequential 32-iteration double-dabble engine, replacing wide combinational divide/modulo logic.
- Arbitrates between competing display writes with a latest-write-wins policy and exposes a busy/status word for CPU polling.

Parameters:
- SEG_HEX_ADDR, 32'hFFFF_FFF0, address for a raw hex digit write.
- LED_ADDR, 32'hFFFF_FFC2, address for an LED write; low 16 bits are used.
- SEG_DEC_ADDR, 32'hFFFF_FFC4, address for an unsigned decimal digit write.
- STATUS_ADDR, 32'hFFFF_FFC6, address of the read-only status word.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- memWrite  in  1  CPU write strobe; one write is sampled per cycle.
- address  in  32  CPU bus address.
- writeData  in  32  CPU write data.
- digits  out  32  packed digit nibbles: s1 = [31:28] (leftmost) … s8 = [3:0]; feeds the Tub decoders and VGA.
- ledOut  out  16  held LED value.
- busy  out  1  decimal conversion in progress.
- overflow  out  1  last committed decimal value was ≥ 10^8.
- statusData  out  32  {30'b0, overflow, busy} when address == STATUS_ADDR, else 0; combinational.

Behaviour:
- Reset (rst = 0, asynchronous):
  - digits = 0, ledOut = 0, busy = 0, overflow = 0.
  - FSM = IDLE; shift register and iteration counter cleared.
  - Takes effect immediately, including mid-conversion; the pending conversion is lost.
- Write decode: a write happens only when memWrite = 1 and address exactly equals one of the three write addresses. Any other address, or memWrite = 0, causes no state change.
- LED write: ledOut <= writeData[15:0] on that edge. Independent of the FSM; accepted in every state.
- Hex write: digits <= writeData on that edge. If the FSM is in CONV or DONE, the conversion is aborted: FSM -> IDLE, busy drops after the same edge, overflow is unchanged.
- Decimal write (any state) on edge E0:
  - Load bin = writeData, clear the 40-bit BCD accumulator, cnt <= 0, FSM -> CONV.
  - A decimal write during CONV or DONE restarts the conversion with the new value; the old one is discarded.
- FSM states:
  - IDLE: busy = 0.
  - CONV: busy = 1.
    - Each edge: every BCD nibble ≥ 5 gets +3.
    - Then {bcd, bin} is shifted left by 1.
    - cnt increments.
    - On the edge where cnt == 31 (32nd iteration, edge E32), FSM -> DONE.
  - DONE: busy = 1.
    - On edge E33: digits <= bcd[31:0], i.e. value mod 10^8.
    - overflow <= (bcd[39:32] != 0).
    - FSM -> IDLE.
- Latency: new digits are visible after edge E33, 33 cycles after the accepting edge E0. busy is high for exactly 33 cycles.
- Digits are never partially updated during CONV; the display holds its previous value until the DONE commit.
- Simultaneous events:
  - Only one address is valid per cycle, so hex and decimal writes cannot coincide.
  - A hex write on the same edge as the DONE commit wins: digits = writeData and no commit occurs.
  - An LED write does not interact with the FSM.
- Arithmetic: the input is unsigned 32-bit, max 4294967295. The BCD accumulator is 40 bits (10 digits), so no internal overflow is possible.

Test Plan:
- Reset, then decimal write of 12345678:
  - busy = 1 for 33 cycles.
  - After E33: digits = 32'h12345678, overflow = 0, busy = 0.
  - digits unchanged (0) before E33.
- Decimal write of 4294967295 -> digits = 32'h94967295, overflow = 1. Then decimal write of 0 -> digits = 0, overflow = 0.
- Decimal write of 99999999; hex write of 32'hDEADBEEF on cycle 10 of CONV:
  - digits = 32'hDEADBEEF on the next edge.
  - busy = 0 on the next edge.
  - No later commit occurs.
- Decimal write of 11111111, then decimal write of 500 at cycle 20 -> busy stays high 33 more cycles; final digits = 32'h00000500.
- LED write of 32'h0001A5A5 during CONV -> ledOut = 16'hA5A5 next edge; the conversion completes normally. A write to 32'hFFFF_FFC8 changes nothing.
- Reset asserted mid-CONV -> digits, ledOut, busy, overflow all 0 immediately. statusData reads 0 at STATUS_ADDR and reads 32'h1 while busy.
